// File: rtl/axil_ctrl_regs.sv
// AXI4-Lite slave register file: CTRL (start pulse / soft reset), STATUS snapshot,
// and N_REGS-2 read/write configuration words, with independent read and write FSMs.
module axil_ctrl_regs #(
    parameter int ADDR_BITS = 32,
    parameter int DATA_BITS = 32,
    parameter int N_REGS    = 8
) (
    input  logic                        aclk,
    input  logic                        areset,

    input  logic [ADDR_BITS-1:0]        s_axil_awaddr,
    input  logic                        s_axil_awvalid,
    output logic                        s_axil_awready,

    input  logic [DATA_BITS-1:0]        s_axil_wdata,
    input  logic [DATA_BITS/8-1:0]      s_axil_wstrb,
    input  logic                        s_axil_wvalid,
    output logic                        s_axil_wready,

    output logic [1:0]                  s_axil_bresp,
    output logic                        s_axil_bvalid,
    input  logic                        s_axil_bready,

    input  logic [ADDR_BITS-1:0]        s_axil_araddr,
    input  logic                        s_axil_arvalid,
    output logic                        s_axil_arready,

    output logic [DATA_BITS-1:0]        s_axil_rdata,
    output logic [1:0]                  s_axil_rresp,
    output logic                        s_axil_rvalid,
    input  logic                        s_axil_rready,

    output logic                        ctrl_start,
    output logic                        ctrl_soft_rst,
    input  logic [DATA_BITS-1:0]        status_in,
    output logic [DATA_BITS*(N_REGS-2)-1:0] cfg_out
);

    localparam int IDX_W = $clog2(N_REGS);
    localparam int N_CFG = N_REGS - 2;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    if (DATA_BITS != 32) begin : g_bad_data_bits
        $error("axil_ctrl_regs: DATA_BITS must be 32");
    end
    if (N_REGS < 4 || (N_REGS & (N_REGS - 1)) != 0) begin : g_bad_n_regs
        $error("axil_ctrl_regs: N_REGS must be a power of 2 and >= 4");
    end

    typedef enum logic {W_IDLE, W_RESP} w_state_t;
    typedef enum logic {R_IDLE, R_DATA} r_state_t;

    w_state_t w_state, w_state_nxt;
    r_state_t r_state, r_state_nxt;

    logic                 soft_rst_q;
    logic [DATA_BITS-1:0] cfg_q [N_CFG];

    logic                 w_acc;
    logic                 r_acc;
    logic [IDX_W-1:0]     widx;
    logic [IDX_W-1:0]     ridx;
    logic                 w_dec_err;
    logic                 r_dec_err;
    logic [DATA_BITS-1:0] rd_val;
    logic                 unused_addr_lsbs;

    function automatic logic [DATA_BITS-1:0] apply_strb(
        input logic [DATA_BITS-1:0]   cur,
        input logic [DATA_BITS-1:0]   wd,
        input logic [DATA_BITS/8-1:0] strb
    );
        logic [DATA_BITS-1:0] res;
        res = cur;
        for (int b = 0; b < DATA_BITS/8; b++) begin
            if (strb[b]) res[8*b +: 8] = wd[8*b +: 8];
        end
        return res;
    endfunction

    // Address decode: word index plus any set bit above the decoded window is an error
    assign widx             = s_axil_awaddr[IDX_W+1:2];
    assign ridx             = s_axil_araddr[IDX_W+1:2];
    assign w_dec_err        = |s_axil_awaddr[ADDR_BITS-1:IDX_W+2];
    assign r_dec_err        = |s_axil_araddr[ADDR_BITS-1:IDX_W+2];
    assign unused_addr_lsbs = ^{s_axil_awaddr[1:0], s_axil_araddr[1:0]};

    always_ff @(posedge aclk) begin
        if (areset) begin
            w_state <= W_IDLE;
            r_state <= R_IDLE;
        end else begin
            w_state <= w_state_nxt;
            r_state <= r_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = w_state;
        case (w_state)
            W_IDLE:  if (w_acc) w_state_nxt = W_RESP;
            W_RESP:  if (s_axil_bready) w_state_nxt = W_IDLE;
            default: w_state_nxt = W_IDLE;
        endcase
        r_state_nxt = r_state;
        case (r_state)
            R_IDLE:  if (r_acc) r_state_nxt = R_DATA;
            R_DATA:  if (s_axil_rready) r_state_nxt = R_IDLE;
            default: r_state_nxt = R_IDLE;
        endcase
    end

    // AW and W are only taken together, in a single cycle
    always_comb begin
        s_axil_awready = (w_state == W_IDLE) && s_axil_awvalid && s_axil_wvalid && !areset;
        s_axil_wready  = s_axil_awready;
        s_axil_bvalid  = (w_state == W_RESP);
        s_axil_arready = (r_state == R_IDLE) && !areset;
        s_axil_rvalid  = (r_state == R_DATA);
    end

    assign w_acc = s_axil_awready;
    assign r_acc = s_axil_arready && s_axil_arvalid;

    always_comb begin
        rd_val = '0;
        if (ridx == IDX_W'(0)) begin
            rd_val = {{(DATA_BITS-2){1'b0}}, soft_rst_q, 1'b0};
        end else if (ridx == IDX_W'(1)) begin
            rd_val = status_in;
        end
        for (int k = 0; k < N_CFG; k++) begin
            if (ridx == IDX_W'(k + 2)) rd_val = cfg_q[k];
        end
        if (r_dec_err) rd_val = '0;
    end

    // Register writes and read-data capture share the edge, so reads see pre-write values
    always_ff @(posedge aclk) begin
        if (areset) begin
            soft_rst_q   <= 1'b0;
            ctrl_start   <= 1'b0;
            s_axil_bresp <= RESP_OKAY;
            s_axil_rresp <= RESP_OKAY;
            s_axil_rdata <= '0;
            for (int k = 0; k < N_CFG; k++) cfg_q[k] <= '0;
        end else begin
            ctrl_start <= 1'b0;
            if (w_acc) begin
                s_axil_bresp <= w_dec_err ? RESP_SLVERR : RESP_OKAY;
                if (!w_dec_err) begin
                    if (widx == IDX_W'(0) && s_axil_wstrb[0]) begin
                        soft_rst_q <= s_axil_wdata[1];
                        ctrl_start <= s_axil_wdata[0];
                    end
                    for (int k = 0; k < N_CFG; k++) begin
                        if (widx == IDX_W'(k + 2))
                            cfg_q[k] <= apply_strb(cfg_q[k], s_axil_wdata, s_axil_wstrb);
                    end
                end
            end
            if (r_acc) begin
                s_axil_rdata <= rd_val;
                s_axil_rresp <= r_dec_err ? RESP_SLVERR : RESP_OKAY;
            end
        end
    end

    assign ctrl_soft_rst = soft_rst_q;

    for (genvar g = 0; g < N_CFG; g++) begin : g_cfg_pack
        assign cfg_out[DATA_BITS*g +: DATA_BITS] = cfg_q[g];
    end

endmodule

// File: tb/tb_axil_ctrl_regs.sv
// Scoreboard bench for axil_ctrl_regs: B/R responses are queued when a request is
// driven and compared by monitors when the handshake is observed.
module tb_axil_ctrl_regs;

    localparam int AB = 32;
    localparam int NR = 8;

    logic              aclk = 1'b0;
    logic              areset;
    logic [AB-1:0]     awaddr, araddr;
    logic              awvalid, awready, wvalid, wready, bvalid, bready;
    logic [31:0]       wdata, rdata, status_in;
    logic [3:0]        wstrb;
    logic [1:0]        bresp, rresp;
    logic              arvalid, arready, rvalid, rready;
    logic              ctrl_start, ctrl_soft_rst;
    logic [32*(NR-2)-1:0] cfg_out;

    int n_vec = 0;
    int n_err = 0;
    int start_cnt = 0;

    logic [1:0]  bq[$];
    logic [33:0] rq[$];

    always #5 aclk = ~aclk;

    axil_ctrl_regs #(.ADDR_BITS(AB), .DATA_BITS(32), .N_REGS(NR)) dut (
        .aclk(aclk), .areset(areset),
        .s_axil_awaddr(awaddr), .s_axil_awvalid(awvalid), .s_axil_awready(awready),
        .s_axil_wdata(wdata), .s_axil_wstrb(wstrb), .s_axil_wvalid(wvalid), .s_axil_wready(wready),
        .s_axil_bresp(bresp), .s_axil_bvalid(bvalid), .s_axil_bready(bready),
        .s_axil_araddr(araddr), .s_axil_arvalid(arvalid), .s_axil_arready(arready),
        .s_axil_rdata(rdata), .s_axil_rresp(rresp), .s_axil_rvalid(rvalid), .s_axil_rready(rready),
        .ctrl_start(ctrl_start), .ctrl_soft_rst(ctrl_soft_rst),
        .status_in(status_in), .cfg_out(cfg_out)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Monitors sample on the falling edge, half a cycle away from the handshake edge
    always @(negedge aclk) begin
        if (ctrl_start === 1'b1) start_cnt++;
        if (bvalid === 1'b1 && bready === 1'b1) begin
            if (bq.size() == 0) chk("b_unexpected", 1, 0);
            else chk("bresp", {62'd0, bresp}, {62'd0, bq.pop_front()});
        end
        if (rvalid === 1'b1 && rready === 1'b1) begin
            if (rq.size() == 0) chk("r_unexpected", 1, 0);
            else chk("rresp_rdata", {30'd0, rresp, rdata}, {30'd0, rq.pop_front()});
        end
    end

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                      input logic [1:0] exp_resp);
        int n;
        awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1;
        bq.push_back(exp_resp);
        #1;
        n = 0;
        while (!awready && n < 20) begin tick(); n++; end
        if (n >= 20) chk("aw_timeout", 0, 1);
        tick();
        awvalid = 1'b0; wvalid = 1'b0;
        chk("b_latency", {63'd0, bvalid}, 64'd1);
        tick();
    endtask

    task automatic rd(input logic [31:0] a, input logic [31:0] exp_d, input logic [1:0] exp_resp);
        int n;
        araddr = a; arvalid = 1'b1;
        rq.push_back({exp_resp, exp_d});
        #1;
        n = 0;
        while (!arready && n < 20) begin tick(); n++; end
        if (n >= 20) chk("ar_timeout", 0, 1);
        tick();
        arvalid = 1'b0;
        chk("r_latency", {63'd0, rvalid}, 64'd1);
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int sc;
        areset = 1'b1; awaddr = '0; araddr = '0; wdata = '0; wstrb = '0;
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0; bready = 1'b1; rready = 1'b1;
        status_in = '0;
        repeat (3) tick();
        awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1;
        #1;
        chk("rst_readies", {61'd0, awready, wready, arready}, 64'd0);
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        chk("rst_valids", {62'd0, bvalid, rvalid}, 64'd0);
        chk("rst_ctrl", {62'd0, ctrl_start, ctrl_soft_rst}, 64'd0);
        chk("rst_cfg", {(256-32*(NR-2)){1'b0}} | 64'(cfg_out[63:0]), 64'd0);
        tick();
        areset = 1'b0;
        tick();

        rd(32'h8, 32'h0, 2'b00);

        wr(32'h8, 32'hDEADBEEF, 4'hF, 2'b00);
        wr(32'h8, 32'h11223344, 4'h2, 2'b00);
        rd(32'h8, 32'hDEAD33EF, 2'b00);
        chk("cfg0", {32'd0, cfg_out[31:0]}, {32'd0, 32'hDEAD33EF});
        rd(32'h9, 32'hDEAD33EF, 2'b00);

        sc = start_cnt;
        wr(32'h8, 32'h00000001, 4'hF, 2'b00);
        chk("no_start_cfg", 64'(start_cnt - sc), 64'd0);
        wr(32'h8, 32'hDEAD33EF, 4'hF, 2'b00);

        sc = start_cnt;
        wr(32'h0, 32'h00000003, 4'hF, 2'b00);
        chk("start_pulse", 64'(start_cnt - sc), 64'd1);
        chk("soft_rst_set", {63'd0, ctrl_soft_rst}, 64'd1);
        rd(32'h0, 32'h00000002, 2'b00);

        sc = start_cnt;
        wr(32'h0, 32'h00000001, 4'hE, 2'b00);
        chk("no_start_strb", 64'(start_cnt - sc), 64'd0);
        chk("soft_rst_hold", {63'd0, ctrl_soft_rst}, 64'd1);
        wr(32'h0, 32'h00000000, 4'h1, 2'b00);
        chk("soft_rst_clr", {63'd0, ctrl_soft_rst}, 64'd0);

        wr(32'h100, 32'hFFFFFFFF, 4'hF, 2'b10);
        chk("decerr_nochg", cfg_out[63:0], {32'd0, 32'hDEAD33EF});
        chk("decerr_ctrl", {63'd0, ctrl_soft_rst}, 64'd0);
        rd(32'h100, 32'h0, 2'b10);

        // AW arrives three cycles before W; the response is then held back by bready
        bready = 1'b0;
        awaddr = 32'hC; awvalid = 1'b1; wvalid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("aw_early", {62'd0, awready, wready}, 64'd0);
            tick();
        end
        wvalid = 1'b1; wdata = 32'h12345678; wstrb = 4'hF;
        bq.push_back(2'b00);
        #1;
        chk("joint_accept", {62'd0, awready, wready}, 64'd3);
        tick();
        awaddr = 32'h10; wdata = 32'hCAFEF00D;
        for (int i = 0; i < 5; i++) begin
            chk("b_hold", {60'd0, bvalid, bresp, awready}, {60'd0, 1'b1, 2'b00, 1'b0});
            tick();
        end
        awvalid = 1'b0; wvalid = 1'b0; bready = 1'b1;
        tick();
        chk("cfg1", {32'd0, cfg_out[63:32]}, {32'd0, 32'h12345678});
        chk("cfg2_untouched", {32'd0, cfg_out[95:64]}, 64'd0);

        // Same-cycle read and write of one register: read sees the old contents
        araddr = 32'h8; arvalid = 1'b1;
        awaddr = 32'h8; wdata = 32'h0BADF00D; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
        rq.push_back({2'b00, 32'hDEAD33EF});
        bq.push_back(2'b00);
        #1;
        chk("dual_accept", {61'd0, arready, awready, wready}, 64'd7);
        tick();
        arvalid = 1'b0; awvalid = 1'b0; wvalid = 1'b0;
        tick();
        chk("cfg0_new", {32'd0, cfg_out[31:0]}, {32'd0, 32'h0BADF00D});

        status_in = 32'hA5A50001;
        araddr = 32'h4; arvalid = 1'b1;
        awaddr = 32'h4; wdata = 32'hFFFFFFFF; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
        rq.push_back({2'b00, 32'hA5A50001});
        bq.push_back(2'b00);
        #1;
        tick();
        arvalid = 1'b0; awvalid = 1'b0; wvalid = 1'b0;
        status_in = 32'h0;
        tick();

        wr(32'h0, 32'h00000002, 4'hF, 2'b00);
        rready = 1'b0;
        araddr = 32'hC; arvalid = 1'b1;
        #1;
        tick();
        arvalid = 1'b0;
        chk("rdata_pending", {63'd0, rvalid}, 64'd1);
        areset = 1'b1;
        tick();
        chk("rst_drop_rvalid", {63'd0, rvalid}, 64'd0);
        chk("rst_cfg_clr", cfg_out[63:0], 64'd0);
        chk("rst_soft_clr", {63'd0, ctrl_soft_rst}, 64'd0);
        areset = 1'b0; rready = 1'b1;
        tick();
        rd(32'hC, 32'h0, 2'b00);

        repeat (2) tick();
        chk("bq_drained", 64'(bq.size()), 64'd0);
        chk("rq_drained", 64'(rq.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
